// File: rtl/raw_sample_framer_pkg.sv
// ============================================================================
// raw_sample_framer_pkg : widths and FSM state type for raw_sample_framer
// Revision 1.0
// ============================================================================
`default_nettype none
`include "const.vh"

package raw_sample_framer_pkg;

    localparam int RAW_WIDTH      = `RAW_WIDTH;
    localparam int INPUT_CHANNELS = `INPUT_CHANNELS;
    localparam int CNT_W          = `ceilLog2(INPUT_CHANNELS);
    localparam int FRAME_W        = RAW_WIDTH * INPUT_CHANNELS;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/const.vh
// Shared sample-format constants for the raw framer and the feature encoder.
`default_nettype none
`ifndef CONST_VH
`define CONST_VH

`define RAW_WIDTH      16
`define INPUT_CHANNELS 4
`define ceilLog2(x)    (((x) <= 1) ? 1 : $clog2(x))

`endif
`default_nettype wire

// File: rtl/raw_sample_framer.sv
// ============================================================================
// raw_sample_framer : assembles serial ADC channel beats into one wide frame
// Revision 1.0
// ============================================================================
`default_nettype none

module raw_sample_framer
    import raw_sample_framer_pkg::*;
(
    input  logic                 Clk_CI,
    input  logic                 Reset_RBI,
    input  logic [RAW_WIDTH-1:0] SampleIn_DI,
    input  logic                 SampleValid_SI,
    input  logic                 FirstChan_SI,
    output logic                 SampleReady_SO,
    output logic [0:FRAME_W-1]   Raw_DO,
    output logic                 ValidOut_SO,
    input  logic                 ReadyIn_SI,
    output logic                 FrameErr_SO
);

    localparam logic [CNT_W-1:0] LAST_CHAN = CNT_W'(INPUT_CHANNELS - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   chan_cntr, chan_cntr_next;
    logic [0:FRAME_W-1] asm_buf, asm_next;
    logic [0:FRAME_W-1] raw_q, raw_next;
    logic               valid_q, valid_next;
    logic               frame_err_q, frame_err_next;
    logic               beat;
    logic               out_xfer;

    assign beat     = SampleValid_SI && (state == COLLECT);
    assign out_xfer = valid_q && ReadyIn_SI;

    always_comb begin
        state_next     = state;
        chan_cntr_next = chan_cntr;
        asm_next       = asm_buf;
        raw_next       = raw_q;
        valid_next     = valid_q && !out_xfer;
        frame_err_next = 1'b0;

        case (state)
            COLLECT: begin
                if (beat) begin
                    if (FirstChan_SI && (chan_cntr != '0)) begin
                        // Resynchronise: this beat starts a fresh frame.
                        frame_err_next            = 1'b1;
                        asm_next[0 +: RAW_WIDTH]  = SampleIn_DI;
                        chan_cntr_next            = CNT_W'(1);
                    end else if (!FirstChan_SI && (chan_cntr == '0)) begin
                        frame_err_next = 1'b1;
                    end else begin
                        asm_next[int'(chan_cntr) * RAW_WIDTH +: RAW_WIDTH] = SampleIn_DI;
                        if (chan_cntr == LAST_CHAN) begin
                            chan_cntr_next = '0;
                            if (!valid_q || out_xfer) begin
                                raw_next   = asm_next;
                                valid_next = 1'b1;
                            end else begin
                                state_next = STALL;
                            end
                        end else begin
                            chan_cntr_next = chan_cntr + CNT_W'(1);
                        end
                    end
                end
            end
            STALL: begin
                // Output register is always occupied here, so ReadyIn means a transfer.
                if (ReadyIn_SI) begin
                    raw_next   = asm_buf;
                    valid_next = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state       <= COLLECT;
            chan_cntr   <= '0;
            asm_buf     <= '0;
            raw_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            chan_cntr   <= chan_cntr_next;
            asm_buf     <= asm_next;
            raw_q       <= raw_next;
            valid_q     <= valid_next;
            frame_err_q <= frame_err_next;
        end
    end

    assign SampleReady_SO = (state == COLLECT);
    assign Raw_DO         = raw_q;
    assign ValidOut_SO    = valid_q;
    assign FrameErr_SO    = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_raw_sample_framer.sv
// ============================================================================
// tb_raw_sample_framer : directed self-checking bench for raw_sample_framer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_raw_sample_framer;
    import raw_sample_framer_pkg::*;

    logic                 clk          = 1'b0;
    logic                 rst_n        = 1'b0;
    logic [RAW_WIDTH-1:0] sample_in    = '0;
    logic                 sample_valid = 1'b0;
    logic                 first_chan   = 1'b0;
    logic                 ready_in     = 1'b0;
    logic                 sample_ready;
    logic [0:FRAME_W-1]   raw_do;
    logic                 valid_out;
    logic                 frame_err;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int err0       = 0;
    int cyc        = 0;
    int total_wait = 0;

    logic [63:0] frames[$];
    logic [63:0] exp_frames[$];
    int          xfer_cyc[$];

    raw_sample_framer dut (
        .Clk_CI         (clk),
        .Reset_RBI      (rst_n),
        .SampleIn_DI    (sample_in),
        .SampleValid_SI (sample_valid),
        .FirstChan_SI   (first_chan),
        .SampleReady_SO (sample_ready),
        .Raw_DO         (raw_do),
        .ValidOut_SO    (valid_out),
        .ReadyIn_SI     (ready_in),
        .FrameErr_SO    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so negedge values match the next edge.
    always @(negedge clk) begin
        if (valid_out && ready_in) begin
            frames.push_back(raw_do);
            xfer_cyc.push_back(cyc);
        end
        if (frame_err) err_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
        return {a, b, c, d};
    endfunction

    task automatic send(input logic [15:0] d, input logic f);
        int waited = 0;
        sample_in    = d;
        first_chan   = f;
        sample_valid = 1'b1;
        while (!sample_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        total_wait += waited;
        if (!sample_ready) check("send_ready_timeout", sample_ready, 1'b1);
        else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        first_chan   = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, 64'(frames.size()), 64'(exp_frames.size()));
        for (int i = 0; i < exp_frames.size() && i < frames.size(); i++)
            check(tag, frames[i], exp_frames[i]);
        frames.delete();
        exp_frames.delete();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", valid_out, 1'b0);
        check("rst_raw", raw_do, 64'h0);
        check("rst_err", frame_err, 1'b0);
        check("rst_ready", sample_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame
        ready_in = 1'b1;
        err0 = err_pulses;
        send(16'h0001, 1'b1); send(16'h0002, 1'b0); send(16'h0003, 1'b0); send(16'h0004, 1'b0);
        check("basic_valid", valid_out, 1'b1);
        check("basic_raw", raw_do, 64'h0001_0002_0003_0004);
        idle(1);
        check("basic_valid_clear", valid_out, 1'b0);
        idle(2);
        check("basic_err", 64'(err_pulses - err0), 64'd0);
        exp_frames.push_back(64'h0001_0002_0003_0004);
        check_frames("basic_frame");

        // Backpressure with two full frames
        ready_in = 1'b0;
        for (int c = 0; c < 4; c++) send(16'(16'h0011 + c), c == 0);
        check("bp_valid", valid_out, 1'b1);
        check("bp_raw_a", raw_do, 64'h0011_0012_0013_0014);
        for (int c = 0; c < 4; c++) send(16'(16'h0021 + c), c == 0);
        check("bp_ready_low", sample_ready, 1'b0);
        check("bp_hold_a", raw_do, 64'h0011_0012_0013_0014);
        idle(3);
        check("bp_hold_a2", raw_do, 64'h0011_0012_0013_0014);
        check("bp_hold_valid", valid_out, 1'b1);
        ready_in = 1'b1;
        idle(1);
        check("bp_raw_b", raw_do, 64'h0021_0022_0023_0024);
        check("bp_valid_b", valid_out, 1'b1);
        check("bp_ready_back", sample_ready, 1'b1);
        idle(1);
        check("bp_valid_clear", valid_out, 1'b0);
        exp_frames.push_back(64'h0011_0012_0013_0014);
        exp_frames.push_back(64'h0021_0022_0023_0024);
        check_frames("bp_frame");

        // Early FirstChan
        err0 = err_pulses;
        send(16'h00A0, 1'b1); send(16'h00B0, 1'b0);
        send(16'h00C0, 1'b1); send(16'h00D0, 1'b0); send(16'h00E0, 1'b0); send(16'h00F0, 1'b0);
        idle(2);
        check("early_err", 64'(err_pulses - err0), 64'd1);
        exp_frames.push_back(mk(16'h00C0, 16'h00D0, 16'h00E0, 16'h00F0));
        check_frames("early_frame");

        // Missing FirstChan straight after reset
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        err0 = err_pulses;
        for (int c = 0; c < 3; c++) send(16'(16'h0031 + c), 1'b0);
        for (int c = 0; c < 4; c++) send(16'(16'h0041 + c), c == 0);
        idle(2);
        check("missing_err", 64'(err_pulses - err0), 64'd3);
        exp_frames.push_back(64'h0041_0042_0043_0044);
        check_frames("missing_frame");

        // Reset mid-frame with a pending output frame
        ready_in = 1'b0;
        for (int c = 0; c < 4; c++) send(16'(16'h0051 + c), c == 0);
        check("rstmid_pre_valid", valid_out, 1'b1);
        send(16'h0061, 1'b1); send(16'h0062, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", valid_out, 1'b0);
        check("rstmid_raw", raw_do, 64'h0);
        check("rstmid_ready", sample_ready, 1'b1);
        sample_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        ready_in = 1'b1;
        err0 = err_pulses;
        send(16'h0071, 1'b0);
        for (int c = 0; c < 4; c++) send(16'(16'h0081 + c), c == 0);
        check("rstmid_new_raw", raw_do, 64'h0081_0082_0083_0084);
        idle(2);
        check("rstmid_err", 64'(err_pulses - err0), 64'd1);
        exp_frames.push_back(64'h0081_0082_0083_0084);
        check_frames("rstmid_frame");

        // Back-to-back streaming
        total_wait = 0;
        xfer_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) send(16'(16'h9000 + k * 16 + c), c == 0);
            exp_frames.push_back(mk(16'(16'h9000 + k * 16), 16'(16'h9001 + k * 16),
                                    16'(16'h9002 + k * 16), 16'(16'h9003 + k * 16)));
        end
        idle(2);
        check("stream_ready_waits", 64'(total_wait), 64'd0);
        if (xfer_cyc.size() >= 3) begin
            check("stream_gap1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd4);
            check("stream_gap2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd4);
        end
        check_frames("stream_frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
